// File: rtl/ksa_pg_stage.sv
// Kogge-Stone pre-processing stage: registered propagate/generate with cin folded into g[0],
// behind a valid/ready handshake with a 2-entry skid buffer. Optional KSA_PG_SUB_EN adds a subtract input.
module ksa_pg_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef KSA_PG_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out,
  output logic             cin_out
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   b_eff, p_in, g_in;
  logic               cin_eff;
  logic [WIDTH-1:0]   skid_p, skid_g;
  logic               skid_cin;
  logic               in_xfer, out_xfer;
  logic               load_main, load_skid, skid_to_main;

  always_comb begin
`ifdef KSA_PG_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = sub | cin;
`else
    b_eff   = b;
    cin_eff = cin;
`endif
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    // cin folded into bit 0 so the prefix tree has no separate carry-in path
    g_in[0] = g_in[0] | (p_in[0] & cin_eff);
  end

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      p_out    <= '0;
      g_out    <= '0;
      cin_out  <= 1'b0;
      skid_p   <= '0;
      skid_g   <= '0;
      skid_cin <= 1'b0;
    end else begin
      state    <= state_nxt;
      // registered from next state so in_ready never depends combinationally on out_ready
      in_ready <= (state_nxt != FULL);
      if (load_main) begin
        p_out   <= p_in;
        g_out   <= g_in;
        cin_out <= cin_eff;
      end else if (skid_to_main) begin
        p_out   <= skid_p;
        g_out   <= skid_g;
        cin_out <= skid_cin;
      end
      if (load_skid) begin
        skid_p   <= p_in;
        skid_g   <= g_in;
        skid_cin <= cin_eff;
      end
    end
  end

endmodule

// File: tb/tb_ksa_pg_stage.sv
// Self-checking bench for ksa_pg_stage: directed scenarios plus randomized traffic against
// an arithmetic reference model (full-adder carry, a+b+cin sum) and an occupancy model.
module tb_ksa_pg_stage;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cin_out, sub;
  logic [W-1:0] a, b, p_out, g_out;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic         c;
    logic [W-1:0] s;
  } pg_t;

  pg_t exp_q[$];
  pg_t obs_q[$];

  ksa_pg_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef KSA_PG_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .g_out(g_out), .cin_out(cin_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic pg_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input logic sb);
    logic [W-1:0] yb;
    logic         ce;
    logic [W:0]   full;
    pg_t          r;
    yb     = sb ? ~y : y;
    ce     = sb ? 1'b1 : ci;
    r.p    = x ^ yb;
    r.g    = x & yb;
    r.g[0] = (int'(x[0]) + int'(yb[0]) + int'(ce)) >= 2;
    r.c    = ce;
    full   = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, ce};
    r.s    = full[W-1:0];
    return r;
  endfunction

  // downstream adder rebuilt from p/g/cin; g[0] already carries cin into bit 1
  function automatic logic [W-1:0] sum_of(input pg_t e);
    logic [W-1:0] s;
    logic         c;
    s[0] = e.p[0] ^ e.c;
    c    = e.g[0];
    for (int i = 1; i < int'(W); i++) begin
      s[i] = e.p[i] ^ c;
      c    = e.g[i] | (e.p[i] & c);
    end
    return s;
  endfunction

  task automatic step();
    pg_t o;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        o.p = p_out; o.g = g_out; o.c = cin_out; o.s = '0;
        o.s = sum_of(o);
        obs_q.push_back(o);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (p_out !== '0) begin errors++; $display("FAIL reset_p_out got=%h exp=0", p_out); end
    checks++; if (g_out !== '0) begin errors++; $display("FAIL reset_g_out got=%h exp=0", g_out); end
    checks++; if (cin_out !== 1'b0) begin errors++; $display("FAIL reset_cin_out got=%b exp=0", cin_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (p_out !== 16'h00FE) begin errors++; $display("FAIL basic_p got=%h exp=00fe", p_out); end
    checks++; if (g_out !== 16'h0001) begin errors++; $display("FAIL basic_g got=%h exp=0001", g_out); end
    checks++; if (cin_out !== 1'b0) begin errors++; $display("FAIL basic_cin got=%b exp=0", cin_out); end
    a = 16'h0001; b = 16'h0000; cin = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (p_out !== 16'h0001) begin errors++; $display("FAIL cinfold_p got=%h exp=0001", p_out); end
    checks++; if (g_out !== 16'h0001) begin errors++; $display("FAIL cinfold_g got=%h exp=0001", g_out); end
    checks++; if (cin_out !== 1'b1) begin errors++; $display("FAIL cinfold_cin got=%b exp=1", cin_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_item%0d got=%h/%h/%b exp=%h/%h/%b", i, obs_q[i].p, obs_q[i].g, obs_q[i].c, exp_q[i].p, exp_q[i].g, exp_q[i].c); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    int           idx;
    pg_t          m;
    ta = '{16'h1234, 16'hFFFF, 16'h8001};
    tb = '{16'h4321, 16'h0001, 16'h7FFF};
    tc = '{1'b0, 1'b1, 1'b1};
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idx = exp_q.size();
      a = ta[idx]; b = tb[idx]; cin = tc[idx];
      step();
    end
    m = model(ta[0], tb[0], tc[0], 1'b0);
    checks++; if (exp_q.size() !== 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", exp_q.size()); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got=%b exp=1", out_valid); end
    checks++; if (p_out !== m.p || g_out !== m.g) begin errors++; $display("FAIL bp_head got=%h/%h exp=%h/%h", p_out, g_out, m.p, m.g); end
    a = ta[2]; b = tb[2]; cin = tc[2];
    out_ready = 1'b1;
    step();
    m = model(ta[1], tb[1], tc[1], 1'b0);
    checks++; if (exp_q.size() !== 2) begin errors++; $display("FAIL full_no_accept got=%0d exp=2", exp_q.size()); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_next got=%b exp=1", in_ready); end
    checks++; if (p_out !== m.p || g_out !== m.g || cin_out !== m.c) begin errors++; $display("FAIL full_skid_to_main got=%h/%h/%b exp=%h/%h/%b", p_out, g_out, cin_out, m.p, m.g, m.c); end
    for (int k = 0; k < 6; k++) begin
      in_valid = (exp_q.size() < 3);
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++; if (obs_q.size() !== 3 || exp_q.size() !== 3) begin errors++; $display("FAIL bp_count got=%0d/%0d exp=3/3", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_item%0d got=%h/%h/%b exp=%h/%h/%b", i, obs_q[i].p, obs_q[i].g, obs_q[i].c, exp_q[i].p, exp_q[i].g, exp_q[i].c); end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'(k);
      step();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b exp=0", in_ready); end
    rst = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (p_out !== '0 || g_out !== '0 || cin_out !== 1'b0) begin errors++; $display("FAIL rstmid_data got=%h/%h/%b exp=0/0/0", p_out, g_out, cin_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
    exp_q.delete();
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got=%b exp=1", in_ready); end
    step(); step(); step();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_stale got=%0d exp=0", obs_q.size()); end
    in_valid = 1'b1; a = 16'hA5A5; b = 16'h5A5B; cin = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++; if (obs_q.size() !== 1 || exp_q.size() !== 1) begin errors++; $display("FAIL rstmid_count got=%0d/%0d exp=1/1", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_item got=%h/%h/%b exp=%h/%h/%b", obs_q[i].p, obs_q[i].g, obs_q[i].c, exp_q[i].p, exp_q[i].g, exp_q[i].c); end
    end
  endtask

  task automatic test_random();
    logic         stalled;
    logic [W-1:0] hp, hg;
    logic         hc;
    int           occ;
    exp_q.delete(); obs_q.delete();
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
`ifdef KSA_PG_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      stalled = out_valid && !out_ready;
      hp = p_out; hg = g_out; hc = cin_out;
      step();
      occ = exp_q.size() - obs_q.size();
      checks++; if (out_valid !== (occ != 0)) begin errors++; $display("FAIL rand_valid n=%0d got=%b occ=%0d", n, out_valid, occ); end
      checks++; if (in_ready !== (occ < 2)) begin errors++; $display("FAIL rand_in_ready n=%0d got=%b occ=%0d", n, in_ready, occ); end
      if (stalled) begin
        checks++; if ({p_out, g_out, cin_out} !== {hp, hg, hc}) begin errors++; $display("FAIL rand_hold n=%0d got=%h/%h/%b exp=%h/%h/%b", n, p_out, g_out, cin_out, hp, hg, hc); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i].p !== exp_q[i].p || obs_q[i].g !== exp_q[i].g || obs_q[i].c !== exp_q[i].c) begin errors++; $display("FAIL rand_item%0d got=%h/%h/%b exp=%h/%h/%b", i, obs_q[i].p, obs_q[i].g, obs_q[i].c, exp_q[i].p, exp_q[i].g, exp_q[i].c); end
      checks++; if (obs_q[i].s !== exp_q[i].s) begin errors++; $display("FAIL rand_sum%0d got=%h exp=%h", i, obs_q[i].s, exp_q[i].s); end
    end
  endtask

`ifdef KSA_PG_SUB_EN
  task automatic test_sub();
    pg_t o;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; sub = 1'b1;
    a = 16'h0005; b = 16'h0003; cin = 1'b0;
    step();
    in_valid = 1'b0; sub = 1'b0;
    o.p = p_out; o.g = g_out; o.c = cin_out; o.s = '0;
    checks++; if (p_out !== 16'hFFF9) begin errors++; $display("FAIL sub_p got=%h exp=fff9", p_out); end
    checks++; if (g_out !== 16'h0005) begin errors++; $display("FAIL sub_g got=%h exp=0005", g_out); end
    checks++; if (cin_out !== 1'b1) begin errors++; $display("FAIL sub_cin got=%b exp=1", cin_out); end
    checks++; if (sum_of(o) !== 16'h0002) begin errors++; $display("FAIL sub_sum got=%h exp=0002", sum_of(o)); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef KSA_PG_SUB_EN
    test_sub();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
